// File: rtl/lcd_bus_monitor_pkg.sv
// rtl/lcd_bus_monitor_pkg.sv - shared HD44780 definitions for the LCD bus monitor
//
// Purpose: init-FSM state type, command opcode masks, DDRAM line base/end
//          addresses, blank character, default timing values and the
//          cursor-step helper used by both cursor-move paths.
// Ports:   none (package).
package lcd_bus_monitor_pkg;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_FS1   = 3'd1,
    S_FS2   = 3'd2,
    S_FS3   = 3'd3,
    S_READY = 3'd4
  } init_state_e;

  // Default timing at 100 MHz
  localparam int unsigned EXEC_CYCLES_DEF  = 3700;
  localparam int unsigned CLEAR_CYCLES_DEF = 152000;
  localparam int unsigned MIN_EN_HIGH_DEF  = 23;

  // Command opcode masks (a command is identified by its highest set bit)
  localparam logic [7:0] OP_SET_DDRAM   = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM   = 8'h40;
  localparam logic [7:0] OP_FUNC_SET    = 8'h20;
  localparam logic [7:0] OP_SHIFT       = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL   = 8'h08;
  localparam logic [7:0] OP_ENTRY_MODE  = 8'h04;
  localparam logic [7:0] OP_HOME        = 8'h02;
  localparam logic [7:0] OP_CLEAR       = 8'h01;

  // Init handshake: three writes with upper nibble 0011, then a function set
  localparam logic [3:0] INIT_NIBBLE    = 4'b0011;
  localparam logic [2:0] FUNC_SET_TOP   = 3'b001;

  // DDRAM line base and end addresses
  localparam logic [6:0] LINE1_BASE     = 7'h00;
  localparam logic [6:0] LINE1_END      = 7'h27;
  localparam logic [6:0] LINE2_BASE     = 7'h40;
  localparam logic [6:0] LINE2_END      = 7'h67;

  localparam logic [7:0] CH_BLANK       = 8'h20;
  localparam int         SHADOW_CELLS   = 32;

  // Step the DDRAM address one position, wrapping between the two lines
  // the same way the controller does.
  function automatic logic [6:0] step_cursor(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr == LINE1_END)      nxt = LINE2_BASE;
      else if (addr == LINE2_END) nxt = LINE1_BASE;
      else                        nxt = addr + 7'd1;
    end else begin
      if (addr == LINE1_BASE)     nxt = LINE2_END;
      else if (addr == LINE2_BASE) nxt = LINE1_END;
      else                        nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - LCD bus synchroniser, en falling-edge detect and en-high width check
//
// Purpose: brings the asynchronous rs/en/data pins into the clk domain,
//          remembers the rs/data seen on the last en-high cycle and measures
//          how long en stayed high.
// Ports:   clk, reset      - clock, async active-high reset
//          lcd_rs/en/data  - raw bus pins
//          fall_pulse      - one cycle, synchronised en went 1 -> 0
//          cap_rs/cap_data - rs/data captured on the last en-high cycle
//          width_ok        - the en-high period lasted at least MIN_EN_HIGH clks
module lcd_bus_sync #(
  parameter int MIN_EN_HIGH = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  output logic       fall_pulse,
  output logic       cap_rs,
  output logic [7:0] cap_data,
  output logic       width_ok
);

  localparam int CW = ($clog2(MIN_EN_HIGH + 1) < 1) ? 1 : $clog2(MIN_EN_HIGH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_EN_HIGH);

  logic       rs_s1_q, rs_s1_d, rs_s2_q, rs_s2_d;
  logic       en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_prev_q, en_prev_d;
  logic [7:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic       cap_rs_q, cap_rs_d;
  logic [7:0] cap_data_q, cap_data_d;
  logic [CW-1:0] width_cnt_q, width_cnt_d;

  always_comb begin
    rs_s1_d     = lcd_rs;
    rs_s2_d     = rs_s1_q;
    en_s1_d     = lcd_en;
    en_s2_d     = en_s1_q;
    en_prev_d   = en_s2_q;
    data_s1_d   = lcd_data;
    data_s2_d   = data_s1_q;
    cap_rs_d    = cap_rs_q;
    cap_data_d  = cap_data_q;
    width_cnt_d = width_cnt_q;

    // Track rs/data while en is high so the write uses the values present
    // just before en fell, not whatever the driver changed afterwards.
    if (en_s2_q) begin
      cap_rs_d   = rs_s2_q;
      cap_data_d = data_s2_q;
    end

    // Counter restarts on en rising and holds through the low phase, so it
    // still carries the high width in the cycle the falling edge is seen.
    if (en_s2_q && !en_prev_q) begin
      width_cnt_d = CW'(1);
    end else if (en_s2_q && (width_cnt_q != CNT_MAX)) begin
      width_cnt_d = width_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_s1_q     <= 1'b0;
      rs_s2_q     <= 1'b0;
      en_s1_q     <= 1'b0;
      en_s2_q     <= 1'b0;
      en_prev_q   <= 1'b0;
      data_s1_q   <= 8'h00;
      data_s2_q   <= 8'h00;
      cap_rs_q    <= 1'b0;
      cap_data_q  <= 8'h00;
      width_cnt_q <= '0;
    end else begin
      rs_s1_q     <= rs_s1_d;
      rs_s2_q     <= rs_s2_d;
      en_s1_q     <= en_s1_d;
      en_s2_q     <= en_s2_d;
      en_prev_q   <= en_prev_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      cap_rs_q    <= cap_rs_d;
      cap_data_q  <= cap_data_d;
      width_cnt_q <= width_cnt_d;
    end
  end

  assign fall_pulse = en_prev_q & ~en_s2_q;
  assign cap_rs     = cap_rs_q;
  assign cap_data   = cap_data_q;
  assign width_ok   = (width_cnt_q >= CNT_MAX);

endmodule

// File: rtl/lcd_bus_monitor.sv
// rtl/lcd_bus_monitor.sv - HD44780 8-bit write-bus monitor with DDRAM shadow and violation flags
//
// Purpose: decodes every write on the observed LCD bus, tracks the init
//          handshake, mirrors the 2x16 visible DDRAM, cursor and display
//          state, and flags writes made too short or while the modelled
//          controller is still busy.
// Ports:   clk, reset               - clock, async active-high reset
//          lcd_rs/lcd_en/lcd_data   - observed bus
//          rd_addr/rd_data          - shadow read port (0-15 line 1, 16-31 line 2)
//          cursor_addr              - current DDRAM address
//          disp_on, mode_8b2l       - display-on bit, 8-bit/2-line mode
//          init_done                - init handshake recognised
//          busy                     - modelled controller busy
//          evt_valid/evt_rs/evt_data- one pulse per decoded write
//          viol_pulse/viol_count    - protocol violation pulse / saturating count
module lcd_bus_monitor
  import lcd_bus_monitor_pkg::*;
#(
  parameter int EXEC_CYCLES  = 3700,
  parameter int CLEAR_CYCLES = 152000,
  parameter int MIN_EN_HIGH  = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_rs,
  input  logic        lcd_en,
  input  logic [7:0]  lcd_data,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [6:0]  cursor_addr,
  output logic        disp_on,
  output logic        mode_8b2l,
  output logic        init_done,
  output logic        busy,
  output logic        evt_valid,
  output logic        evt_rs,
  output logic [7:0]  evt_data,
  output logic        viol_pulse,
  output logic [15:0] viol_count
);

  localparam int BMAX = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int BW   = ($clog2(BMAX + 1) < 1) ? 1 : $clog2(BMAX + 1);

  logic       fall_pulse, cap_rs, width_ok;
  logic [7:0] cap_data;

  lcd_bus_sync #(
    .MIN_EN_HIGH (MIN_EN_HIGH)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .fall_pulse (fall_pulse),
    .cap_rs     (cap_rs),
    .cap_data   (cap_data),
    .width_ok   (width_ok)
  );

  init_state_e state_q, state_d;
  logic          init_done_q, init_done_d;
  logic          mode_q, mode_d;
  logic          disp_on_q, disp_on_d;
  logic          id_inc_q, id_inc_d;
  logic [6:0]    cursor_q, cursor_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic          fill_active_q, fill_active_d;
  logic [4:0]    fill_idx_q, fill_idx_d;
  logic [7:0]    shadow_q [SHADOW_CELLS];
  logic [7:0]    shadow_d [SHADOW_CELLS];
  logic          evt_valid_q, evt_valid_d;
  logic          evt_rs_q, evt_rs_d;
  logic [7:0]    evt_data_q, evt_data_d;
  logic          viol_pulse_q, viol_pulse_d;
  logic [15:0]   viol_count_q, viol_count_d;

  logic busy_now;
  logic viol, load_exec, load_clear, start_fill;

  assign busy_now = (busy_cnt_q != '0) | fill_active_q;

  always_comb begin
    state_d       = state_q;
    init_done_d   = init_done_q;
    mode_d        = mode_q;
    disp_on_d     = disp_on_q;
    id_inc_d      = id_inc_q;
    cursor_d      = cursor_q;
    fill_active_d = fill_active_q;
    fill_idx_d    = fill_idx_q;
    shadow_d      = shadow_q;
    evt_valid_d   = 1'b0;
    evt_rs_d      = evt_rs_q;
    evt_data_d    = evt_data_q;
    viol_pulse_d  = 1'b0;
    viol_count_d  = viol_count_q;
    viol          = 1'b0;
    load_exec     = 1'b0;
    load_clear    = 1'b0;
    start_fill    = 1'b0;

    busy_cnt_d = (busy_cnt_q != '0) ? (busy_cnt_q - BW'(1)) : busy_cnt_q;

    // Clear fill: one blank per clock, running alongside the busy timer.
    if (fill_active_q) begin
      shadow_d[fill_idx_q] = CH_BLANK;
      fill_idx_d           = fill_idx_q + 5'd1;
      if (fill_idx_q == 5'd31) begin
        fill_active_d = 1'b0;
      end
    end

    if (fall_pulse) begin
      evt_valid_d = 1'b1;
      evt_rs_d    = cap_rs;
      evt_data_d  = cap_data;

      // A short en pulse is flagged but the write still takes effect.
      if (!width_ok) begin
        viol = 1'b1;
      end

      // Before the third init write the real controller cannot report
      // busy, so the timing check only starts from S_FS3.
      if (busy_now && (state_q == S_FS3 || state_q == S_READY)) begin
        viol = 1'b1;
      end else begin
        case (state_q)
          S_WAIT, S_FS1, S_FS2: begin
            if (!cap_rs && (cap_data[7:4] == INIT_NIBBLE)) begin
              load_exec = 1'b1;
              case (state_q)
                S_WAIT:  state_d = S_FS1;
                S_FS1:   state_d = S_FS2;
                default: state_d = S_FS3;
              endcase
            end else begin
              state_d = S_WAIT;
              viol    = 1'b1;
            end
          end
          S_FS3: begin
            // Only the final function set is meaningful here; anything
            // else is flagged and the handshake waits for it.
            if (!cap_rs && (cap_data[7:5] == FUNC_SET_TOP)) begin
              state_d     = S_READY;
              init_done_d = 1'b1;
              mode_d      = cap_data[4] & cap_data[3];
              load_exec   = 1'b1;
            end else begin
              viol = 1'b1;
            end
          end
          default: begin
            if (cap_rs) begin
              if (cursor_q[6:4] == 3'b000) begin
                shadow_d[{1'b0, cursor_q[3:0]}] = cap_data;
              end else if (cursor_q[6:4] == 3'b100) begin
                shadow_d[{1'b1, cursor_q[3:0]}] = cap_data;
              end
              cursor_d  = step_cursor(cursor_q, id_inc_q);
              load_exec = 1'b1;
            end else begin
              casez (cap_data)
                8'b1???????: begin
                  cursor_d  = cap_data[6:0];
                  load_exec = 1'b1;
                end
                8'b01??????: begin
                  load_exec = 1'b1;
                end
                8'b001?????: begin
                  mode_d    = cap_data[4] & cap_data[3];
                  load_exec = 1'b1;
                end
                8'b0001????: begin
                  cursor_d  = step_cursor(cursor_q, cap_data[2]);
                  load_exec = 1'b1;
                end
                8'b00001???: begin
                  disp_on_d = cap_data[2];
                  load_exec = 1'b1;
                end
                8'b000001??: begin
                  id_inc_d  = cap_data[1];
                  load_exec = 1'b1;
                end
                8'b0000001?: begin
                  cursor_d   = LINE1_BASE;
                  load_clear = 1'b1;
                end
                8'b00000001: begin
                  cursor_d   = LINE1_BASE;
                  id_inc_d   = 1'b1;
                  start_fill = 1'b1;
                  load_clear = 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end

    if (load_exec)  busy_cnt_d = BW'(EXEC_CYCLES);
    if (load_clear) busy_cnt_d = BW'(CLEAR_CYCLES);
    if (start_fill) begin
      fill_active_d = 1'b1;
      fill_idx_d    = 5'd0;
    end

    // Short-en and busy on the same write still count once.
    if (viol) begin
      viol_pulse_d = 1'b1;
      if (viol_count_q != 16'hFFFF) begin
        viol_count_d = viol_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_WAIT;
      init_done_q   <= 1'b0;
      mode_q        <= 1'b0;
      disp_on_q     <= 1'b0;
      id_inc_q      <= 1'b0;
      cursor_q      <= 7'h00;
      busy_cnt_q    <= '0;
      fill_active_q <= 1'b0;
      fill_idx_q    <= 5'd0;
      for (int i = 0; i < SHADOW_CELLS; i++) begin
        shadow_q[i] <= CH_BLANK;
      end
      evt_valid_q   <= 1'b0;
      evt_rs_q      <= 1'b0;
      evt_data_q    <= 8'h00;
      viol_pulse_q  <= 1'b0;
      viol_count_q  <= 16'h0000;
    end else begin
      state_q       <= state_d;
      init_done_q   <= init_done_d;
      mode_q        <= mode_d;
      disp_on_q     <= disp_on_d;
      id_inc_q      <= id_inc_d;
      cursor_q      <= cursor_d;
      busy_cnt_q    <= busy_cnt_d;
      fill_active_q <= fill_active_d;
      fill_idx_q    <= fill_idx_d;
      shadow_q      <= shadow_d;
      evt_valid_q   <= evt_valid_d;
      evt_rs_q      <= evt_rs_d;
      evt_data_q    <= evt_data_d;
      viol_pulse_q  <= viol_pulse_d;
      viol_count_q  <= viol_count_d;
    end
  end

  assign rd_data     = shadow_q[rd_addr];
  assign cursor_addr = cursor_q;
  assign disp_on     = disp_on_q;
  assign mode_8b2l   = mode_q;
  assign init_done   = init_done_q;
  assign busy        = busy_now;
  assign evt_valid   = evt_valid_q;
  assign evt_rs      = evt_rs_q;
  assign evt_data    = evt_data_q;
  assign viol_pulse  = viol_pulse_q;
  assign viol_count  = viol_count_q;

endmodule
